// File: rtl/nv_clkgate_ctrl_if.sv
// Port bundle for the clock-gate sequencer: per-domain requests and configuration in,
// gating-cell enables and domain status out.
interface nv_clkgate_ctrl_if #(
  parameter int NUM_DOM = 4,
  parameter int CNT_W   = 8
);
  // Level protocol, no transfer handshake: dom_req held high asks for the domain clock
  // and must stay high until dom_rdy is seen; dom_rdy high means the gated clock is
  // stable and the domain is usable in that cycle. Dropping dom_req never aborts a wake.
  logic [NUM_DOM-1:0]   dom_req;
  logic [NUM_DOM-1:0]   dom_idle;
  logic [CNT_W-1:0]     cfg_hold;
  logic                 cfg_cg_disable;
  logic [NUM_DOM-1:0]   cg_en;
  logic [NUM_DOM-1:0]   dom_rdy;
  logic [NUM_DOM-1:0]   dom_gated;
  logic [2*NUM_DOM-1:0] dbg_state;

  modport master (
    output dom_req, dom_idle, cfg_hold, cfg_cg_disable,
    input  cg_en, dom_rdy, dom_gated, dbg_state
  );

  modport slave (
    input  dom_req, dom_idle, cfg_hold, cfg_cg_disable,
    output cg_en, dom_rdy, dom_gated, dbg_state
  );
endinterface

// File: rtl/nv_clkgate_ctrl.sv
// Per-domain clock-gate sequencer: idle-hold gating, round-robin rate-limited wake-up,
// and a ready indication once each restored clock has settled.
module nv_clkgate_ctrl #(
  parameter int NUM_DOM  = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_LAT = 2,
  parameter int MAX_WAKE = 1
) (
  input logic               nvdla_core_clk,
  input logic               nvdla_core_rst,
  nv_clkgate_ctrl_if.slave  cg
);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } dom_state_e;

  localparam int WK_W  = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam int PTR_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [WK_W-1:0] WAKE_LAST = WK_W'(WAKE_LAT - 1);

  dom_state_e         state_q [NUM_DOM];
  dom_state_e         state_d [NUM_DOM];
  logic [CNT_W-1:0]   hold_q  [NUM_DOM];
  logic [CNT_W-1:0]   hold_d  [NUM_DOM];
  logic [WK_W-1:0]    wake_q  [NUM_DOM];
  logic [WK_W-1:0]    wake_d  [NUM_DOM];
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_DOM-1:0] cg_en_q, cg_en_d;
  logic [NUM_DOM-1:0] rdy_q, rdy_d;
  logic [NUM_DOM-1:0] gated_q, gated_d;

  logic [NUM_DOM-1:0] quiet;
  logic [NUM_DOM-1:0] is_off;
  logic [NUM_DOM-1:0] cand;
  logic [NUM_DOM-1:0] grant;
  logic [PTR_W-1:0]   idx;
  int                 n_busy;
  int                 n_slots;
  int                 n_grant;
  int                 last_idx;
  int                 sum;

  assign quiet = cg.dom_idle & ~cg.dom_req & {NUM_DOM{~cg.cfg_cg_disable}};

  always_comb begin
    for (int d = 0; d < NUM_DOM; d++) begin
      is_off[d] = (state_q[d] == ST_OFF);
    end
  end

  assign cand = is_off & (cg.dom_req | {NUM_DOM{cg.cfg_cg_disable}});

  // A domain on its last WAKE cycle frees its slot now, so the next wake can
  // overlap its hand-off and the WAKE population never exceeds MAX_WAKE.
  always_comb begin
    n_busy   = 0;
    n_grant  = 0;
    last_idx = -1;
    sum      = 0;
    idx      = '0;
    grant    = '0;
    for (int d = 0; d < NUM_DOM; d++) begin
      if (state_q[d] == ST_WAKE && wake_q[d] != WAKE_LAST) n_busy++;
    end
    n_slots = MAX_WAKE - n_busy;
    for (int k = 0; k < NUM_DOM; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= NUM_DOM) sum = sum - NUM_DOM;
      idx = PTR_W'(sum);
      if (cand[idx] && n_grant < n_slots) begin
        grant[idx] = 1'b1;
        n_grant++;
        last_idx = sum;
      end
    end
    ptr_d = ptr_q;
    if (last_idx >= 0) ptr_d = (last_idx == NUM_DOM - 1) ? '0 : PTR_W'(last_idx + 1);
  end

  always_comb begin
    for (int d = 0; d < NUM_DOM; d++) begin
      state_d[d] = state_q[d];
      hold_d[d]  = hold_q[d];
      wake_d[d]  = wake_q[d];
      unique case (state_q[d])
        ST_ON: begin
          if (quiet[d]) begin
            if (hold_q[d] >= cg.cfg_hold) begin
              state_d[d] = ST_OFF;
              hold_d[d]  = '0;
            end else if (hold_q[d] != '1) begin
              hold_d[d] = hold_q[d] + CNT_W'(1);
            end
          end else begin
            hold_d[d] = '0;
          end
        end
        ST_OFF: begin
          if (grant[d]) begin
            state_d[d] = ST_WAKE;
            wake_d[d]  = '0;
          end
        end
        ST_WAKE: begin
          if (wake_q[d] == WAKE_LAST) begin
            state_d[d] = ST_ON;
            wake_d[d]  = '0;
          end else begin
            wake_d[d] = wake_q[d] + WK_W'(1);
          end
        end
        default: begin
          state_d[d] = ST_ON;
          hold_d[d]  = '0;
          wake_d[d]  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from next state so they are flops aligned with state_q.
  always_comb begin
    for (int d = 0; d < NUM_DOM; d++) begin
      cg_en_d[d] = (state_d[d] != ST_OFF);
      rdy_d[d]   = (state_d[d] == ST_ON);
      gated_d[d] = (state_d[d] == ST_OFF);
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      for (int d = 0; d < NUM_DOM; d++) begin
        state_q[d] <= ST_ON;
        hold_q[d]  <= '0;
        wake_q[d]  <= '0;
      end
      ptr_q   <= '0;
      cg_en_q <= '1;
      rdy_q   <= '1;
      gated_q <= '0;
    end else begin
      for (int d = 0; d < NUM_DOM; d++) begin
        state_q[d] <= state_d[d];
        hold_q[d]  <= hold_d[d];
        wake_q[d]  <= wake_d[d];
      end
      ptr_q   <= ptr_d;
      cg_en_q <= cg_en_d;
      rdy_q   <= rdy_d;
      gated_q <= gated_d;
    end
  end

  assign cg.cg_en     = cg_en_q;
  assign cg.dom_rdy   = rdy_q;
  assign cg.dom_gated = gated_q;

  always_comb begin
    cg.dbg_state = '0;
    for (int d = 0; d < NUM_DOM; d++) begin
      cg.dbg_state[2*d +: 2] = state_q[d];
    end
  end

endmodule

// File: tb/tb_nv_clkgate_ctrl.sv
// Bench for nv_clkgate_ctrl: directed scenarios plus random traffic, every cycle
// compared against a counting reference model of the gating rules.
module tb_nv_clkgate_ctrl;

  localparam int NUM_DOM  = 4;
  localparam int CNT_W    = 8;
  localparam int WAKE_LAT = 2;
  localparam int MAX_WAKE = 1;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_bad;

  nv_clkgate_ctrl_if #(.NUM_DOM(NUM_DOM), .CNT_W(CNT_W)) cg_if ();

  nv_clkgate_ctrl #(
    .NUM_DOM(NUM_DOM), .CNT_W(CNT_W), .WAKE_LAT(WAKE_LAT), .MAX_WAKE(MAX_WAKE)
  ) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .cg(cg_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", tag, act, exp_v, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Each domain is described by: off flag, remaining wake cycles, and the
  // length of its current run of consecutive quiet cycles while running.
  bit m_off  [NUM_DOM];
  int m_wake [NUM_DOM];
  int m_run  [NUM_DOM];
  int m_ptr;

  task automatic model_reset();
    for (int d = 0; d < NUM_DOM; d++) begin
      m_off[d] = 1'b0; m_wake[d] = 0; m_run[d] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic model_step(input logic [NUM_DOM-1:0] req, input logic [NUM_DOM-1:0] idle,
                            input logic [CNT_W-1:0] hold, input logic dis);
    int busy, slots, granted, last, d;
    bit gnt [NUM_DOM];
    busy = 0;
    for (int i = 0; i < NUM_DOM; i++) begin
      gnt[i] = 1'b0;
      if (m_wake[i] > 1) busy++;
    end
    slots = MAX_WAKE - busy;
    granted = 0;
    last = -1;
    for (int k = 0; k < NUM_DOM; k++) begin
      d = (m_ptr + k) % NUM_DOM;
      if (m_off[d] && (req[d] || dis) && granted < slots) begin
        gnt[d] = 1'b1; granted++; last = d;
      end
    end
    for (int i = 0; i < NUM_DOM; i++) begin
      if (m_off[i]) begin
        if (gnt[i]) begin m_off[i] = 1'b0; m_wake[i] = WAKE_LAT; end
      end else if (m_wake[i] > 0) begin
        m_wake[i]--;
      end else if (idle[i] && !req[i] && !dis) begin
        if (m_run[i] >= int'(hold)) begin m_off[i] = 1'b1; m_run[i] = 0; end
        else m_run[i]++;
      end else begin
        m_run[i] = 0;
      end
    end
    if (last >= 0) m_ptr = (last + 1) % NUM_DOM;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0]        exp_q[$];
  int                 fall_cg  [NUM_DOM];
  int                 rise_cg  [NUM_DOM];
  int                 rise_rdy [NUM_DOM];
  logic [NUM_DOM-1:0] prev_cg, prev_rdy;

  task automatic clr_ev();
    for (int d = 0; d < NUM_DOM; d++) begin
      fall_cg[d] = -1; rise_cg[d] = -1; rise_rdy[d] = -1;
    end
  endtask

  always @(negedge clk) begin
    logic [NUM_DOM-1:0] e_cg, e_rdy, e_gt;
    if (rst) begin
      model_reset();
    end else begin
      for (int d = 0; d < NUM_DOM; d++) begin
        e_cg[d]  = !m_off[d];
        e_rdy[d] = !m_off[d] && m_wake[d] == 0;
        e_gt[d]  = m_off[d];
        if (prev_cg[d] && !cg_if.cg_en[d])    fall_cg[d]  = cyc;
        if (!prev_cg[d] && cg_if.cg_en[d])    rise_cg[d]  = cyc;
        if (!prev_rdy[d] && cg_if.dom_rdy[d]) rise_rdy[d] = cyc;
      end
      chk("cg_en", 32'(cg_if.cg_en), 32'(e_cg));
      chk("dom_rdy", 32'(cg_if.dom_rdy), 32'(e_rdy));
      chk("dom_gated", 32'(cg_if.dom_gated), 32'(e_gt));
      chk("wake_bound", 32'($countones(cg_if.cg_en & ~cg_if.dom_rdy) <= MAX_WAKE), 32'd1);
      model_step(cg_if.dom_req, cg_if.dom_idle, cg_if.cfg_hold, cg_if.cfg_cg_disable);
    end
    prev_cg  = cg_if.cg_en;
    prev_rdy = cg_if.dom_rdy;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [NUM_DOM-1:0] idle, input logic [CNT_W-1:0] hold);
    rst = 1'b1;
    cg_if.dom_req = '0;
    cg_if.dom_idle = idle;
    cg_if.cfg_hold = hold;
    cg_if.cfg_cg_disable = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, p, q, n;
    logic [6:0] pat;
    n_chk = 0;
    n_bad = 0;
    clr_ev();
    prev_cg = '1;
    prev_rdy = '1;
    rst = 1'b1;
    cg_if.dom_req = '0;
    cg_if.dom_idle = '0;
    cg_if.cfg_hold = 8'd3;
    cg_if.cfg_cg_disable = 1'b0;
    #1;
    chk("rst_cg_en", 32'(cg_if.cg_en), 32'hf);
    chk("rst_rdy", 32'(cg_if.dom_rdy), 32'hf);
    chk("rst_gated", 32'(cg_if.dom_gated), 32'h0);

    // idle hold gating of domain 0
    tick(2);
    rst = 1'b0;
    tick(1);
    cg_if.dom_idle = 4'b0001;
    t = cyc;
    tick(6);
    chk("hold_fall", 32'(fall_cg[0] - t), 32'd4);
    chk("hold_gated", 32'(cg_if.dom_gated), 32'b0001);
    chk("hold_others", 32'(cg_if.cg_en[3:1]), 32'b111);

    // single-cycle wake pulse then regate
    clr_ev();
    cg_if.dom_req = 4'b0001;
    t = cyc;
    tick(1);
    cg_if.dom_req = '0;
    tick(10);
    chk("wake_cg_rise", 32'(rise_cg[0] - t), 32'd1);
    chk("wake_rdy_rise", 32'(rise_rdy[0] - t), 32'd3);
    chk("wake_regate", 32'(fall_cg[0] - t), 32'd7);

    // four simultaneous wakes, one at a time in round-robin order
    do_reset(4'b1111, 8'd3);
    n = 0;
    while (cg_if.dom_gated != 4'b1111 && n < 20) begin tick(1); n++; end
    chk("all_off", 32'(cg_if.dom_gated), 32'hf);
    clr_ev();
    cg_if.dom_req = 4'b1111;
    t = cyc;
    for (int d = 0; d < NUM_DOM; d++) exp_q.push_back(32'(t + 3 + 2 * d));
    tick(12);
    cg_if.dom_req = '0;
    for (int d = 0; d < NUM_DOM; d++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk($sformatf("rr_rdy_d%0d", d), 32'(rise_rdy[d]), e);
    end
    tick(6);

    // idle toggle clears the hold counter
    do_reset(4'b0000, 8'd3);
    clr_ev();
    pat = 7'b1111011;
    p = 0;
    for (int i = 0; i < 7; i++) begin
      cg_if.dom_idle[1] = pat[i];
      if (i == 3) p = cyc;
      tick(1);
    end
    tick(8);
    chk("toggle_fall", 32'(fall_cg[1] - p), 32'd4);

    // maximum hold time: 256 quiet cycles
    cg_if.cfg_hold = 8'd255;
    tick(10);
    cg_if.dom_idle[2] = 1'b1;
    q = cyc;
    tick(262);
    chk("sat_fall", 32'(fall_cg[2] - q), 32'd256);

    // gating disable wakes OFF domains and suppresses regating
    do_reset(4'b0011, 8'd2);
    tick(6);
    chk("dis_pre_gated", 32'(cg_if.dom_gated), 32'b0011);
    clr_ev();
    cg_if.cfg_cg_disable = 1'b1;
    t = cyc;
    tick(20);
    chk("dis_rdy_d0", 32'(rise_rdy[0] - t), 32'd3);
    chk("dis_rdy_d1", 32'(rise_rdy[1] - t), 32'd5);
    chk("dis_no_gate", 32'(cg_if.dom_gated), 32'h0);
    clr_ev();
    cg_if.cfg_cg_disable = 1'b0;
    t = cyc;
    tick(6);
    chk("undis_fall_d0", 32'(fall_cg[0] - t), 32'd3);
    chk("undis_fall_d1", 32'(fall_cg[1] - t), 32'd3);
    chk("undis_busy_on", 32'(cg_if.cg_en[3:2]), 32'b11);

    // asynchronous reset while domain 0 is waking
    cg_if.dom_req = 4'b0001;
    tick(1);
    chk("arst_pre_wake", 32'(cg_if.dom_rdy[0]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cg_en", 32'(cg_if.cg_en), 32'hf);
    chk("arst_rdy", 32'(cg_if.dom_rdy), 32'hf);
    chk("arst_gated", 32'(cg_if.dom_gated), 32'h0);
    tick(2);
    cg_if.dom_req = '0;
    rst = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      for (int d = 0; d < NUM_DOM; d++) begin
        cg_if.dom_req[d]  = ($urandom_range(0, 99) < 15);
        cg_if.dom_idle[d] = ($urandom_range(0, 99) < 75);
      end
      if (i % 64 == 0) cg_if.cfg_hold = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 99) < 2) cg_if.cfg_cg_disable = ~cg_if.cfg_cg_disable;
      tick(1);
    end
    cg_if.cfg_cg_disable = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
